fifo_uart_tx: RTL
=================

# fifo_uart_tx

Serial transmit back end that drains the byte FIFO: whenever the FIFO holds data and transmission is enabled, it pops one byte and serializes it as an 8N1/8N2 UART frame on `tx`. It is the reader on the FIFO's dequeue side, mirroring the writer that enqueues bytes. It sits between the FIFO and the board's UART TX pin in the pComputer I/O path.

## Interface
Parameters:
- `CLKS_PER_BIT`, 54: clock cycles per serial bit; must be ≥ 2.
- `STOP_BITS`, 1: number of stop bits; legal values are 1 and 2.

Ports:
- `clk` in 1: sole clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_en` in 1: when low, no new byte is popped; a frame already in flight always completes.
- `fifo_empty` in 1: FIFO has no data.
- `fifo_dout` in 8: FIFO head byte, first-word fall-through; valid whenever `fifo_empty` is low.
- `dequeue` out 1: pops the FIFO head on this clock edge.
- `tx` out 1: serial line; idles high.
- `busy` out 1: high while a frame is in progress.

## Operation
- FSM states:
  - IDLE: `tx` high, `busy` low.
  - START: `tx` low.
  - DATA: `tx` = `shreg[0]`, LSB first, 8 bits.
  - STOP: `tx` high, for `STOP_BITS` bit times.
- Pop condition `pop` = `tx_en` & ~`fifo_empty` & (state==IDLE | last cycle of STOP).
- `dequeue` = `pop`, combinational, single-cycle by construction.
- On a `pop` edge:
  - `shreg` ← `fifo_dout`.
  - Bit counter ← 0; baud counter ← 0.
  - State ← START.
- Baud counter:
  - Width is clog2(`CLKS_PER_BIT`).
  - Counts 0..`CLKS_PER_BIT`-1, then wraps; a wrap marks the end of a bit.
- State transitions at end of bit:
  - START → DATA.
  - DATA: shift `shreg` right by 1; after bit index 7 → STOP.
  - STOP: after the last stop bit → START if `pop`, else → IDLE.
- `busy` = (state != IDLE).
- `fifo_dout` is sampled only on the `pop` edge. Later changes to `fifo_dout` do not affect the frame in flight.
- `tx_en` deasserted mid-frame: the frame finishes normally, then the FSM goes to IDLE.
- FIFO empty at end of STOP: go to IDLE; `tx` stays high.
- Reset, at any time including mid-frame:
  - state = IDLE, `tx` = 1, `busy` = 0, `dequeue` = 0.
  - Counters and `shreg` = 0.
  - The partially sent byte is lost and is not re-popped.

## Timing
- `tx` is driven from a register, so the line is glitch-free.
- Pop at edge N: `tx` falls in the cycle after edge N, i.e. one clock of latency from `dequeue` to the start bit.
- Frame length is exactly (9 + `STOP_BITS`) × `CLKS_PER_BIT` cycles, counted from the first START cycle to the last STOP cycle.
- Back-to-back frames have zero idle gap: the next START cycle directly follows the last STOP cycle.
- `dequeue` is asserted for exactly one cycle per byte and never while `fifo_empty` is high.
- While `rst_n` is low, `dequeue` is forced to 0.

## Structure
- Shared package holds the state encoding enum `uart_tx_state_t`.
- The package also holds the frame data width constant (8).
- No sub-module. The baud counter is an inline counter in the module body; a separate `baud_gen` is not warranted for a single user.

## Test plan
Bench uses `CLKS_PER_BIT`=4, `STOP_BITS`=1.

1. Reset: hold `rst_n`=0 with `fifo_empty`=0 and `tx_en`=1.
   - Required: `tx`=1, `busy`=0, `dequeue`=0 throughout.
2. Single byte: FIFO holds 0x09, then goes empty after the pop.
   - `dequeue` pulses for 1 cycle.
   - `tx` bits, 4 cycles each: 0,1,0,0,1,0,0,0,0,1.
   - Then `tx` stays 1 and `busy` falls after 40 cycles.
3. Back-to-back: FIFO holds 0x09 then 0x08.
   - Second `dequeue` occurs in the last STOP cycle of the first frame.
   - The second start bit follows with no gap.
   - Second frame data bits, LSB first: 0,0,0,1,0,0,0,0.
4. `tx_en` gating: `tx_en`=0 while the FIFO is non-empty.
   - No `dequeue`; `tx`=1.
   - Raise `tx_en`: `dequeue` in that same cycle, start bit on the next cycle.
5. Disable mid-frame: drop `tx_en` during DATA.
   - The frame completes all 40 cycles.
   - No further `dequeue`; `busy`=0 afterwards.
6. Reset mid-frame: pull `rst_n` low during DATA bit 3.
   - `tx` goes high immediately (asynchronously).
   - After release with the FIFO non-empty, the next byte is popped and a fresh frame starts.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared state encoding and frame constants for the FIFO-draining UART transmitter.
package fifo_uart_tx_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
endpackage

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a fall-through FIFO and sends them as 8N1/8N2 UART frames.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 54,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              dequeue,
  output logic              tx,
  output logic              busy
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  uart_tx_state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_idx, bit_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic tx_n, bit_end, last_stop, pop;
  assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
  assign last_stop = state == STOP && bit_end && bit_idx == 3'(STOP_BITS - 1);
  // rst_n gate keeps dequeue low while the FSM is held in IDLE by reset
  assign pop = rst_n && tx_en && !fifo_empty && (state == IDLE || last_stop);
  assign dequeue = pop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
    end
  end
  // bit_idx counts data bits, then wraps to 0 and counts stop bits
  always_comb begin
    state_n = pop ? START :
              state == START && bit_end ? DATA :
              state == DATA && bit_end && bit_idx == 3'd7 ? STOP :
              last_stop ? IDLE : state;
    baud_n  = (pop || state_n == IDLE || bit_end) ? '0 : baud + BW'(1);
    bit_n   = (pop || state_n == IDLE) ? '0 :
              bit_end && (state == DATA || state == STOP) ? bit_idx + 3'd1 : bit_idx;
    shreg_n = pop ? fifo_dout : state == DATA && bit_end ? shreg >> 1 : shreg;
  end
  always_comb begin
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : 1'b1;
    busy = state != IDLE;
  end
endmodule
